// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: opcodes, ALU and forward-select
// encodings, per-stage control bundles and the instruction decoder.
package pipe_pkg;

  localparam int OPC_BITS = 6;

  typedef logic [OPC_BITS-1:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_JUMP  = 6'b000010;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_ADDI  = 6'b001000;
  localparam opcode_t OP_ANDI  = 6'b001100;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;
  localparam opcode_t OP_RIMM  = 6'b110000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_LOGIC = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10
  } fwd_sel_e;

  // Full bundle held in ID/EX; later stages keep only the bits they still need.
  typedef struct packed {
    logic    mem_to_reg;
    alu_op_e alu_op;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    logic    branch;
    logic    jump;
  } ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  reg_dst;
    logic  uses_rs;
    logic  uses_rt;
    logic  legal;
  } decode_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic decode_t decode_op(input opcode_t op);
    decode_t d;
    d = '0;
    d.legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        d.reg_dst        = 1'b1;
        d.ctrl.alu_op    = ALU_FUNCT;
        d.ctrl.reg_write = 1'b1;
        d.uses_rs        = 1'b1;
        d.uses_rt        = 1'b1;
      end
      OP_JUMP: begin
        d.ctrl.jump = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl.alu_op = ALU_SUB;
        d.ctrl.branch = 1'b1;
        d.uses_rs     = 1'b1;
        d.uses_rt     = 1'b1;
      end
      OP_ADDI: begin
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.uses_rs        = 1'b1;
      end
      OP_ANDI: begin
        d.ctrl.alu_op    = ALU_LOGIC;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.uses_rs        = 1'b1;
      end
      OP_LW: begin
        d.ctrl.mem_to_reg = 1'b1;
        d.ctrl.mem_read   = 1'b1;
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.reg_write  = 1'b1;
        d.uses_rs         = 1'b1;
      end
      OP_SW: begin
        d.ctrl.mem_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.uses_rs        = 1'b1;
        d.uses_rt        = 1'b1;
      end
      OP_RIMM: begin
        d.reg_dst        = 1'b1;
        d.ctrl.alu_op    = ALU_FUNCT;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.reg_write = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pipe_control_hazard_unit.sv
// Stall, flush and operand-forwarding decisions, purely combinational from pipeline state.
// PIPE_CONTROL_FWD_EN selects forwarding with load-use stalls; otherwise interlock-only.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            id_jump,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_branch,
  input  logic            ex_branch_taken,
  input  logic [RA_W-1:0] ex_dst,
  input  logic [RA_W-1:0] ex_rs,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] mem_dst,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_dst,
  output logic            stall,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic writes(input logic rw, input logic [RA_W-1:0] dst,
                                  input logic [RA_W-1:0] src);
    return rw && (dst != '0) && (dst == src);
  endfunction

  logic branch_flush;
  logic hit_ex;
  logic hit_mem;
  logic hazard;

  always_comb begin
    branch_flush = ex_branch && ex_branch_taken;
    hit_ex  = (id_uses_rs && writes(ex_reg_write, ex_dst, id_rs)) ||
              (id_uses_rt && writes(ex_reg_write, ex_dst, id_rt));
    hit_mem = (id_uses_rs && writes(mem_reg_write, mem_dst, id_rs)) ||
              (id_uses_rt && writes(mem_reg_write, mem_dst, id_rt));
  end

`ifdef PIPE_CONTROL_FWD_EN
  always_comb begin
    hazard = ex_mem_read && hit_ex;
    fwd_a  = FWD_REGFILE;
    fwd_b  = FWD_REGFILE;
    if (writes(mem_reg_write, mem_dst, ex_rs))     fwd_a = FWD_MEM;
    else if (writes(wb_reg_write, wb_dst, ex_rs))  fwd_a = FWD_WB;
    if (writes(mem_reg_write, mem_dst, ex_rt))     fwd_b = FWD_MEM;
    else if (writes(wb_reg_write, wb_dst, ex_rt))  fwd_b = FWD_WB;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_mem_read, ex_rs, ex_rt, wb_reg_write, wb_dst};

  always_comb begin
    hazard = hit_ex || hit_mem;
    fwd_a  = FWD_REGFILE;
    fwd_b  = FWD_REGFILE;
  end
`endif

  // A taken branch kills the dependent instruction anyway, so it overrides the stall;
  // a stalled jump is simply re-evaluated once the stall clears.
  always_comb begin
    stall       = hazard && !branch_flush;
    flush_id_ex = branch_flush;
    flush_if_id = branch_flush || (id_jump && !stall);
  end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control: decode in ID plus the ID/EX, EX/MEM and MEM/WB control registers.
// Forwarding behaviour is selected by PIPE_CONTROL_FWD_EN inside hazard_unit.
module pipe_control
  import pipe_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_branch_taken,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [RA_W-1:0]  wb_dst,
  output logic [RA_W-1:0]  ex_rs,
  output logic [RA_W-1:0]  ex_rt,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             illegal_op
);

  decode_t         dec_raw;
  decode_t         id_dec;
  logic            id_legal;
  logic [RA_W-1:0] id_dst;
  logic            kill_id;

  ctrl_t           idex_ctrl;
  logic [RA_W-1:0] idex_dst;
  logic [RA_W-1:0] idex_rs;
  logic [RA_W-1:0] idex_rt;
  logic            illegal_q;

  mem_ctrl_t       exmem_ctrl;
  logic [RA_W-1:0] exmem_dst;

  wb_ctrl_t        memwb_ctrl;
  logic [RA_W-1:0] memwb_dst;

  // Opcode bits above the architected field must be zero for a legal instruction.
  always_comb begin
    dec_raw  = decode_op(opcode_t'(id_opcode));
    id_legal = dec_raw.legal && ((id_opcode >> OPC_BITS) == '0);
    id_dec   = dec_raw;
    if (!id_legal) id_dec = '0;
    id_dst   = id_dec.reg_dst ? id_rd : id_rt;
  end

  hazard_unit #(.RA_W(RA_W)) u_hazard (
    .id_uses_rs      (id_dec.uses_rs),
    .id_uses_rt      (id_dec.uses_rt),
    .id_jump         (id_dec.ctrl.jump),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_reg_write    (idex_ctrl.reg_write),
    .ex_mem_read     (idex_ctrl.mem_read),
    .ex_branch       (idex_ctrl.branch),
    .ex_branch_taken (ex_branch_taken),
    .ex_dst          (idex_dst),
    .ex_rs           (idex_rs),
    .ex_rt           (idex_rt),
    .mem_reg_write   (exmem_ctrl.reg_write),
    .mem_dst         (exmem_dst),
    .wb_reg_write    (memwb_ctrl.reg_write),
    .wb_dst          (memwb_dst),
    .stall           (stall),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  assign kill_id = stall || flush_id_ex;

  // A stalled or flushed ID instruction becomes a bubble; the illegal pulse is only
  // raised for an undecodable instruction that really advances out of ID.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex_ctrl <= CTRL_BUBBLE;
      idex_dst  <= '0;
      idex_rs   <= '0;
      idex_rt   <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= !id_legal && !kill_id;
      if (kill_id || !id_legal) begin
        idex_ctrl <= CTRL_BUBBLE;
        idex_dst  <= '0;
        idex_rs   <= '0;
        idex_rt   <= '0;
      end else begin
        idex_ctrl <= id_dec.ctrl;
        idex_dst  <= id_dst;
        idex_rs   <= id_rs;
        idex_rt   <= id_rt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exmem_ctrl <= '0;
      exmem_dst  <= '0;
    end else begin
      exmem_ctrl.mem_read   <= idex_ctrl.mem_read;
      exmem_ctrl.mem_write  <= idex_ctrl.mem_write;
      exmem_ctrl.reg_write  <= idex_ctrl.reg_write;
      exmem_ctrl.mem_to_reg <= idex_ctrl.mem_to_reg;
      exmem_dst             <= idex_dst;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      memwb_ctrl <= '0;
      memwb_dst  <= '0;
    end else begin
      memwb_ctrl.reg_write  <= exmem_ctrl.reg_write;
      memwb_ctrl.mem_to_reg <= exmem_ctrl.mem_to_reg;
      memwb_dst             <= exmem_dst;
    end
  end

  always_comb begin
    ex_alu_op     = idex_ctrl.alu_op;
    ex_alu_src    = idex_ctrl.alu_src;
    ex_branch     = idex_ctrl.branch;
    ex_jump       = idex_ctrl.jump;
    ex_rs         = idex_rs;
    ex_rt         = idex_rt;
    mem_read      = exmem_ctrl.mem_read;
    mem_write     = exmem_ctrl.mem_write;
    wb_reg_write  = memwb_ctrl.reg_write;
    wb_mem_to_reg = memwb_ctrl.mem_to_reg;
    wb_dst        = memwb_dst;
    illegal_op    = illegal_q;
  end

endmodule
